sfif_tx_seq: RTL and testbench

- Transmit TLP sequencer for the PCIe x1 throughput design. Runs on the 125 MHz user clock.
- Generates a programmed burst of 32-bit-address memory-write (MWr32) or memory-read (MRd32) TLPs on the core's 16-bit TX interface.
- For each TLP it drives the credit-demand strobes (cp_ph, cp_pd, cp_nph) into the credit-check stage. It consumes that stage's registered credit_available before requesting the link.
- Reports progress and credit-stall statistics to the control registers.

---
 rtl/sfif_tx_seq.sv | 191 +++++++++++++++++++
 tb/tb_sfif_tx_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfif_tx_seq.sv
// Transmit TLP sequencer: issues a programmed burst of MWr32/MRd32 TLPs on the 16-bit
// core TX interface, gating each TLP on a credit check and tracking progress/stalls.
module sfif_tx_seq #(
    parameter logic [15:0] REQ_ID  = 16'h0000,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic        clk_125,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic        tlp_rd,
    input  logic [9:0]  len_dw,
    input  logic [15:0] tlp_count,
    input  logic [31:0] base_addr,
    input  logic        credit_available,
    input  logic        tx_rdy,
    output logic        cp_ph,
    output logic [3:0]  cp_pd,
    output logic        cp_nph,
    output logic        tx_req,
    output logic [15:0] tx_data,
    output logic        tx_st,
    output logic        tx_end,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [2:0] {StIdle, StChk, StReq, StStrm, StGap} state_e;

    state_e      state_q;
    logic        rd_q;
    logic [9:0]  len_q;
    logic [15:0] count_q;
    logic [31:0] addr_q;
    logic [7:0]  tag_q;
    logic [7:0]  beat_q;
    logic [3:0]  gap_q;
    logic        settle_q;
    logic        abort_q;

    logic [7:0]  nxt_beat;
    logic [6:0]  pay_dw;
    logic [7:0]  last_beat;
    logic [31:0] beat_dw;
    logic [15:0] nxt_half;

    function automatic logic [3:0] pd_demand(input logic [9:0] len);
        return 4'((len + 10'd7) >> 3);
    endfunction

    // Halfword for the beat after the one currently presented; beat_q = FF selects beat 0.
    always_comb begin
        nxt_beat  = beat_q + 8'd1;
        pay_dw    = 7'((nxt_beat - 8'd6) >> 1);
        last_beat = rd_q ? 8'd5 : {len_q[6:0], 1'b0} + 8'd5;
        if (nxt_beat < 8'd6) begin
            case (nxt_beat[2:1])
                2'd0:    beat_dw = {1'b0, rd_q ? 2'b00 : 2'b10, 5'b00000, 8'h00, 6'h00, len_q};
                2'd1:    beat_dw = {REQ_ID, tag_q, (len_q == 10'd1) ? 4'h0 : 4'hF, 4'hF};
                default: beat_dw = addr_q;
            endcase
        end else begin
            beat_dw = {sent_cnt, 9'd0, pay_dw};
        end
        nxt_half = nxt_beat[0] ? beat_dw[15:0] : beat_dw[31:16];
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            rd_q      <= 1'b0;
            len_q     <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            settle_q  <= 1'b0;
            abort_q   <= 1'b0;
            cp_ph     <= 1'b0;
            cp_pd     <= '0;
            cp_nph    <= 1'b0;
            tx_req    <= 1'b0;
            tx_data   <= '0;
            tx_st     <= 1'b0;
            tx_end    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sent_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        rd_q      <= tlp_rd;
                        len_q     <= len_dw;
                        count_q   <= tlp_count;
                        addr_q    <= base_addr & 32'hFFFF_FFFC;
                        tag_q     <= '0;
                        sent_cnt  <= '0;
                        stall_cnt <= '0;
                        abort_q   <= 1'b0;
                        settle_q  <= 1'b1;
                        beat_q    <= 8'hFF;
                        busy      <= 1'b1;
                        cp_ph     <= ~tlp_rd;
                        cp_pd     <= tlp_rd ? 4'd0 : pd_demand(len_dw);
                        cp_nph    <= tlp_rd;
                        state_q   <= StChk;
                    end
                end
                StChk: begin
                    settle_q <= 1'b0;
                    if (abort) begin
                        cp_ph   <= 1'b0;
                        cp_pd   <= '0;
                        cp_nph  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end else if (!settle_q) begin
                        if (credit_available) begin
                            cp_ph   <= 1'b0;
                            cp_pd   <= '0;
                            cp_nph  <= 1'b0;
                            tx_req  <= 1'b1;
                            state_q <= StReq;
                        end else if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                StReq: begin
                    if (abort) abort_q <= 1'b1;
                    if (tx_rdy) begin
                        tx_req  <= 1'b0;
                        tx_data <= nxt_half;
                        tx_st   <= 1'b1;
                        tx_end  <= (nxt_beat == last_beat);
                        beat_q  <= nxt_beat;
                        state_q <= StStrm;
                    end
                end
                StStrm: begin
                    if (abort) abort_q <= 1'b1;
                    if (tx_rdy) begin
                        if (tx_end) begin
                            tx_data  <= '0;
                            tx_st    <= 1'b0;
                            tx_end   <= 1'b0;
                            sent_cnt <= sent_cnt + 16'd1;
                            tag_q    <= tag_q + 8'd1;
                            addr_q   <= addr_q + {20'd0, len_q, 2'b00};
                            gap_q    <= '0;
                            state_q  <= StGap;
                        end else begin
                            tx_data <= nxt_half;
                            tx_st   <= 1'b0;
                            tx_end  <= (nxt_beat == last_beat);
                            beat_q  <= nxt_beat;
                        end
                    end
                end
                StGap: begin
                    if (abort) abort_q <= 1'b1;
                    if (gap_q == 4'(GAP_CYC - 1)) begin
                        if (sent_cnt == count_q || abort || abort_q) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            settle_q <= 1'b1;
                            beat_q   <= 8'hFF;
                            cp_ph    <= ~rd_q;
                            cp_pd    <= rd_q ? 4'd0 : pd_demand(len_q);
                            cp_nph   <= rd_q;
                            state_q  <= StChk;
                        end
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sfif_tx_seq.sv
// Randomised and directed bench for sfif_tx_seq against a TLP-level reference model.
module tb_sfif_tx_seq;

    localparam logic [15:0] REQ_ID  = 16'h0000;
    localparam int unsigned GAP_CYC = 2;
    localparam int          Limit   = 20000;

    logic        clk_125 = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tlp_rd = 1'b0;
    logic [9:0]  len_dw = '0;
    logic [15:0] tlp_count = '0;
    logic [31:0] base_addr = '0;
    logic        credit_available = 1'b0;
    logic        tx_rdy = 1'b0;
    logic        cp_ph, cp_nph, tx_req, tx_st, tx_end, busy, done;
    logic [3:0]  cp_pd;
    logic [15:0] tx_data, sent_cnt, stall_cnt;

    always #4 clk_125 = ~clk_125;

    sfif_tx_seq #(.REQ_ID(REQ_ID), .GAP_CYC(GAP_CYC)) dut (
        .clk_125(clk_125), .rstn(rstn), .start(start), .abort(abort), .tlp_rd(tlp_rd),
        .len_dw(len_dw), .tlp_count(tlp_count), .base_addr(base_addr),
        .credit_available(credit_available), .tx_rdy(tx_rdy), .cp_ph(cp_ph), .cp_pd(cp_pd),
        .cp_nph(cp_nph), .tx_req(tx_req), .tx_data(tx_data), .tx_st(tx_st), .tx_end(tx_end),
        .busy(busy), .done(done), .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;
    int cred_pct = 100;
    int rdy_low = 0;

    // Reference model state for the current burst
    bit          m_rd;
    int          m_len;
    logic [31:0] m_base;
    int          exp_tlp, exp_beat, exp_stall, beats_acc, chk_run;
    bit          streaming, cred_ok, held_valid;
    logic [15:0] held_data;
    logic        held_end, held_st;
    logic [15:0] act_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_half(input int tlp, input int beat);
        logic [31:0] dw;
        if (beat < 6) begin
            case (beat / 2)
                0:       dw = (m_rd ? 32'h0 : 32'h4000_0000) | (32'(m_len) & 32'h3FF);
                1:       dw = {REQ_ID, 8'(tlp), (m_len == 1) ? 4'h0 : 4'hF, 4'hF};
                default: dw = (m_base + 32'(tlp * m_len * 4)) & 32'hFFFF_FFFC;
            endcase
        end else begin
            dw = {16'(tlp), 16'((beat - 6) / 2)};
        end
        return (beat % 2 == 0) ? dw[31:16] : dw[15:0];
    endfunction

    // Input driver: random grant and credit, with a forced-low window for tx_rdy
    always @(posedge clk_125) begin
        #1;
        if (rdy_low > 0) begin
            tx_rdy = 1'b0;
            rdy_low--;
        end else begin
            tx_rdy = (int'($urandom_range(99)) < rdy_pct);
        end
        credit_available = (int'($urandom_range(99)) < cred_pct);
    end

    // Monitor: outputs and inputs are stable at the falling edge
    always @(negedge clk_125) begin
        int nbeats;
        nbeats = m_rd ? 6 : 6 + 2 * m_len;
        if (!rstn) begin
            streaming  = 1'b0;
            chk_run    = 0;
            held_valid = 1'b0;
        end else begin
            if (cp_ph || cp_nph || (cp_pd != 4'd0)) begin
                chk_run++;
                check_eq("cp_ph", 32'(cp_ph), 32'(!m_rd));
                check_eq("cp_pd", 32'(cp_pd), 32'(m_rd ? 0 : (m_len + 7) / 8));
                check_eq("cp_nph", 32'(cp_nph), 32'(m_rd));
                check_eq("req_in_chk", 32'(tx_req), 32'd0);
                if (chk_run >= 2 && !abort) begin
                    if (!credit_available) begin
                        if (exp_stall < 65535) exp_stall++;
                    end else begin
                        cred_ok = 1'b1;
                    end
                end
            end else begin
                chk_run = 0;
            end
            if (tx_req) check_eq("req_after_credit", 32'(cred_ok), 32'd1);
            if (streaming) begin
                if (held_valid) begin
                    check_eq("hold_data", 32'(tx_data), 32'(held_data));
                    check_eq("hold_end", 32'(tx_end), 32'(held_end));
                    check_eq("hold_st", 32'(tx_st), 32'(held_st));
                    held_valid = 1'b0;
                end
                if (tx_rdy) begin
                    check_eq("beat_data", 32'(tx_data), 32'(ref_half(exp_tlp, exp_beat)));
                    check_eq("beat_st", 32'(tx_st), 32'(exp_beat == 0));
                    check_eq("beat_end", 32'(tx_end), 32'(exp_beat == nbeats - 1));
                    act_q.push_back(tx_data);
                    beats_acc++;
                    if (exp_beat == nbeats - 1) begin
                        exp_tlp++;
                        exp_beat  = 0;
                        streaming = 1'b0;
                    end else begin
                        exp_beat++;
                    end
                end else begin
                    held_valid = 1'b1;
                    held_data  = tx_data;
                    held_end   = tx_end;
                    held_st    = tx_st;
                end
            end else if (tx_req && tx_rdy) begin
                streaming = 1'b1;
                cred_ok   = 1'b0;
                exp_beat  = 0;
            end
        end
    end

    task automatic start_burst(input bit rd, input int len, input int cnt,
                               input logic [31:0] base);
        m_rd = rd; m_len = len; m_base = base;
        exp_tlp = 0; exp_beat = 0; exp_stall = 0; beats_acc = 0; cred_ok = 1'b0;
        act_q.delete();
        @(posedge clk_125); #1;
        tlp_rd = rd; len_dw = 10'(len); tlp_count = 16'(cnt); base_addr = base; start = 1'b1;
        @(posedge clk_125); #1;
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int exp_sent);
        int n = 0;
        while (!done && n < Limit) begin
            @(negedge clk_125);
            n++;
        end
        #1;
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("sent_cnt", 32'(sent_cnt), 32'(exp_sent));
        check_eq("tlps_seen", 32'(exp_tlp), 32'(exp_sent));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk_125);
        check_eq("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic wait_cp;
        int n = 0;
        @(negedge clk_125);
        while (!(cp_ph || cp_nph) && n < 50) begin
            @(negedge clk_125);
            n++;
        end
        check_eq("chk_entered", 32'(cp_ph || cp_nph), 32'd1);
    endtask

    initial begin
        logic [15:0] exp1[8];
        int n;
        exp1 = '{16'h4000, 16'h0001, 16'h0000, 16'h000F, 16'h0000, 16'h1000, 16'h0000, 16'h0000};

        #20;
        check_eq("rst_ctrl", 32'({tx_req, tx_st, tx_end, busy, done, cp_ph, cp_nph, cp_pd}), 0);
        check_eq("rst_data", 32'({tx_data, sent_cnt}), 0);
        @(negedge clk_125);
        rstn = 1'b1;

        // Single-DW write with known beat values
        start_burst(1'b0, 1, 1, 32'h0000_1000);
        wait_done(1);
        check_eq("t1_beats", 32'(act_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < act_q.size()) check_eq("t1_beat", 32'(act_q[i]), 32'(exp1[i]));

        // Three max-length reads
        start_burst(1'b1, 64, 3, 32'h0000_2000);
        wait_done(3);
        check_eq("t2_beats", 32'(act_q.size()), 32'd18);
        if (act_q.size() == 18) begin
            check_eq("t2_len", 32'(act_q[1]), 32'h0040);
            check_eq("t2_addr0", 32'(act_q[5]), 32'h2000);
            check_eq("t2_addr1", 32'(act_q[11]), 32'h2100);
            check_eq("t2_tag2", 32'(act_q[15]), 32'h02FF);
            check_eq("t2_addr2", 32'(act_q[17]), 32'h2200);
        end

        // Credit stall of exactly ten cycles after the settle cycle
        cred_pct = 0;
        start_burst(1'b0, 4, 1, 32'h0000_3000);
        wait_cp();
        repeat (10) @(negedge clk_125);
        cred_pct = 100;
        wait_done(1);
        check_eq("t3_stall", 32'(stall_cnt), 32'd10);

        // Backpressure mid-payload
        start_burst(1'b0, 8, 1, 32'h0000_4000);
        n = 0;
        while (beats_acc < 10 && n < 200) begin
            @(negedge clk_125); #1;
            n++;
        end
        rdy_low = 3;
        wait_done(1);
        check_eq("t4_beats", 32'(beats_acc), 32'd22);

        // Abort in the middle of TLP 2 of 5
        start_burst(1'b0, 4, 5, 32'h0000_5000);
        n = 0;
        while (!(exp_tlp == 1 && exp_beat >= 3) && n < 500) begin
            @(negedge clk_125); #1;
            n++;
        end
        abort = 1'b1;
        wait_done(2);
        abort = 1'b0;

        // Abort while waiting for credit
        cred_pct = 0;
        start_burst(1'b1, 2, 3, 32'h0000_6000);
        wait_cp();
        abort = 1'b1;
        wait_done(0);
        abort = 1'b0;
        cred_pct = 100;

        // Asynchronous reset mid-payload, then a clean burst
        start_burst(1'b0, 16, 2, 32'h0000_7000);
        n = 0;
        while (beats_acc < 12 && n < 200) begin
            @(negedge clk_125); #1;
            n++;
        end
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_ctrl", 32'({tx_req, tx_st, tx_end, busy, done, cp_ph, cp_nph, cp_pd}), 0);
        check_eq("mid_rst_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst_cnt", 32'({sent_cnt, stall_cnt}), 32'd0);
        repeat (2) @(negedge clk_125);
        rstn = 1'b1;
        start_burst(1'b0, 3, 2, 32'h0000_8000);
        wait_done(2);

        // Randomised bursts
        for (int b = 0; b < 6; b++) begin
            int cnt;
            rdy_pct  = int'($urandom_range(100, 50));
            cred_pct = int'($urandom_range(100, 30));
            cnt      = int'($urandom_range(4, 1));
            start_burst(1'($urandom_range(1, 0)), int'($urandom_range(64, 1)), cnt, $urandom);
            wait_done(cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
